kypd_scanner: RTL and testbench
===============================

# kypd_scanner

Matrix scanner for the 4x4 Pmod keypad, directly upstream of `keypad_decoder`. It drives one column low at a time and samples the four row lines. It debounces the result over whole scans and presents a stable 4-bit key code on `key_value_o`, which connects straight to `key_value_i` of the decoder.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column is driven; sampling happens on the last of them; legal range 4..65535.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full-scan results required before commit; legal range 1..15.

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `row_i`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `clk_i`.
- `col_o`  out  4  keypad columns, one-hot-low; the driven column is 0.
- `key_value_o`  out  4  committed key code (hex of key label).
- `key_valid_o`  out  1  high while a committed key is pressed.
- `key_press_o`  out  1  one-cycle pulse when a new pressed key is committed.

## Operation
- Key map (row r, column c):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: 0, F, E, D
- `row_i` passes through a 2-flop synchronizer before any use.
- Column FSM states COL0..COL3, each lasting `SCAN_DIV` cycles. A 16-bit divide counter runs 0..`SCAN_DIV`-1. In state COLn, `col_o` = ~(1<<n). The terminal count advances n and wraps COL3 -> COL0.
- Sampling happens at terminal count of each column. The first low synchronized row wins:
  - Columns are scanned in order 0..3.
  - Within a column, rows are checked in order 0..3.
  - Later hits in the same scan are ignored, which covers multi-key presses.
- Scan result at the end of COL3 is {hit, code}. No hit gives {0, 4'h0}.
- Debounce: a 4-bit counter `stab` tracks repeated results.
  - If the result equals the previous scan's result, `stab` = min(`stab`+1, `DEBOUNCE_SCANS`); otherwise `stab` = 1.
  - When `stab` reaches `DEBOUNCE_SCANS` and the result differs from the committed {valid, value}, the result is committed.
- Commit of a hit:
  - `key_valid_o` = 1 and `key_value_o` = code.
  - `key_press_o` pulses if the previous committed state was not-valid or held a different code.
- Commit of no-hit: `key_valid_o` = 0; `key_value_o` behaves per Configuration.
- Key "0" and no-key both yield code 4'h0; `key_valid_o` distinguishes them. The downstream decoder maps both to its default.
- Reset mid-scan returns the FSM to COL0 at count 0, clears the synchronizer, `stab`, the previous result and the committed state. No pulse is issued on reset release.

## Timing
- Reset values:
  - `col_o` = 4'b1110
  - `key_value_o` = 4'h0
  - `key_valid_o` = 0
  - `key_press_o` = 0
- One full scan takes 4*`SCAN_DIV` cycles. Outputs change only on the cycle after the COL3 terminal count.
- Commit latency is `DEBOUNCE_SCANS` complete scans in which the key is seen continuously, plus 1 cycle. The worst case from a stable press is (`DEBOUNCE_SCANS`+1)*4*`SCAN_DIV`+3 cycles.
- `SCAN_DIV` ≥ 4 guarantees the 2-flop synchronizer has settled on the new column before sampling.
- `key_press_o` is high for exactly one cycle, coincident with the `key_value_o` update.
- A press shorter than `DEBOUNCE_SCANS` scans produces no output change. Results alternating between scans keep resetting `stab` to 1, so nothing commits.

## Configuration
- `KYPD_HOLD_LAST_EN` defined: on release commit, `key_value_o` keeps the last pressed code, so the downstream tone stays on the last note.
- `KYPD_HOLD_LAST_EN` undefined: on release commit, `key_value_o` returns to 4'h0.
- `key_valid_o` and `key_press_o` behave identically in both builds.

## Test plan
Unless stated, `SCAN_DIV`=4 and `DEBOUNCE_SCANS`=3.
- Reset check: assert reset, release, no keys pressed -> `col_o` steps 1110, 1101, 1011, 0111 every 4 cycles; outputs stay 0/0/0 indefinitely.
- Single key: hold key "5" (row1 low only while col1 driven) from reset release -> after 3 scans + 1 cycle (49 cycles), `key_value_o`=4'h5, `key_valid_o`=1, a single `key_press_o` pulse.
- Release, both builds: release "5" -> 3 scans later `key_valid_o`=0; `key_value_o`=4'h0 without the macro, stays 4'h5 with `KYPD_HOLD_LAST_EN`.
- Glitch rejection: press "C" for 2 scans (32 cycles), then release -> no output change, no pulse.
- Multi-key and key change:
  - Hold "2" and "D" together -> commits 4'h2.
  - Change to "D" alone -> commits 4'hD with a new pulse.
- Reset mid-operation: assert reset during COL2 with "9" committed -> `col_o`=1110 and outputs 0 immediately. Keep "9" held -> recommits after 49 cycles with a pulse.

Source files
------------

// File: rtl/kypd_scanner.sv
// 4x4 keypad matrix scanner: column drive, row sampling, whole-scan debounce.
// Optional build macro KYPD_HOLD_LAST_EN keeps the last pressed code on release.
module kypd_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_value_o,
  output logic       key_valid_o,
  output logic       key_press_o
);

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } col_state_e;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_MAX   = 4'(DEBOUNCE_SCANS);

  col_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  row_s1_q, row_s2_q;
  logic        scan_hit_q, scan_hit_d;
  logic [3:0]  scan_code_q, scan_code_d;
  logic [4:0]  prev_q, prev_d;
  logic [3:0]  stab_q, stab_d;
  logic        cmt_valid_q, cmt_valid_d;
  logic [3:0]  cmt_code_q, cmt_code_d;
  logic [3:0]  value_q, value_d;
  logic        press_q, press_d;

  logic        tc;
  logic        row_hit;
  logic [1:0]  row_idx;
  logic        res_hit;
  logic [3:0]  res_code;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0:    k = 4'h1;
      4'h1:    k = 4'h2;
      4'h2:    k = 4'h3;
      4'h3:    k = 4'hA;
      4'h4:    k = 4'h4;
      4'h5:    k = 4'h5;
      4'h6:    k = 4'h6;
      4'h7:    k = 4'hB;
      4'h8:    k = 4'h7;
      4'h9:    k = 4'h8;
      4'hA:    k = 4'h9;
      4'hB:    k = 4'hC;
      4'hC:    k = 4'h0;
      4'hD:    k = 4'hF;
      4'hE:    k = 4'hE;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign col_o       = ~(4'b0001 << state_q);
  assign key_value_o = value_q;
  assign key_valid_o = cmt_valid_q;
  assign key_press_o = press_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    scan_hit_d  = scan_hit_q;
    scan_code_d = scan_code_q;
    prev_d      = prev_q;
    stab_d      = stab_q;
    cmt_valid_d = cmt_valid_q;
    cmt_code_d  = cmt_code_q;
    value_d     = value_q;
    press_d     = 1'b0;

    tc      = (cnt_q == DIV_LAST);
    row_hit = ~&row_s2_q;
    if (!row_s2_q[0])      row_idx = 2'd0;
    else if (!row_s2_q[1]) row_idx = 2'd1;
    else if (!row_s2_q[2]) row_idx = 2'd2;
    else                   row_idx = 2'd3;

    // First hit of the scan wins; later hits are ignored
    res_hit  = scan_hit_q;
    res_code = scan_code_q;
    if (!scan_hit_q && row_hit) begin
      res_hit  = 1'b1;
      res_code = key_code(row_idx, state_q);
    end

    if (tc) begin
      cnt_d   = 16'd0;
      state_d = col_state_e'(state_q + 2'd1);
      if (state_q == COL3) begin
        scan_hit_d  = 1'b0;
        scan_code_d = 4'h0;
        prev_d      = {res_hit, res_code};
        if ({res_hit, res_code} == prev_q)
          stab_d = (stab_q >= DB_MAX) ? DB_MAX : stab_q + 4'd1;
        else
          stab_d = 4'd1;
        if (stab_d == DB_MAX && (res_hit != cmt_valid_q || res_code != cmt_code_q)) begin
          cmt_valid_d = res_hit;
          cmt_code_d  = res_code;
          press_d     = res_hit;
`ifdef KYPD_HOLD_LAST_EN
          if (res_hit) value_d = res_code;
`else
          value_d = res_code;
`endif
        end
      end else begin
        scan_hit_d  = res_hit;
        scan_code_d = res_code;
      end
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= COL0;
      cnt_q       <= 16'd0;
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      scan_hit_q  <= 1'b0;
      scan_code_q <= 4'h0;
      prev_q      <= 5'd0;
      stab_q      <= 4'd0;
      cmt_valid_q <= 1'b0;
      cmt_code_q  <= 4'h0;
      value_q     <= 4'h0;
      press_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_s1_q    <= row_i;
      row_s2_q    <= row_s1_q;
      scan_hit_q  <= scan_hit_d;
      scan_code_q <= scan_code_d;
      prev_q      <= prev_d;
      stab_q      <= stab_d;
      cmt_valid_q <= cmt_valid_d;
      cmt_code_q  <= cmt_code_d;
      value_q     <= value_d;
      press_q     <= press_d;
    end
  end

endmodule

// File: tb/tb_kypd_scanner.sv
// Bench for kypd_scanner: keypad matrix model, scan-level reference model,
// per-cycle compare plus literal spot checks.
module tb_kypd_scanner;

  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic [3:0]  key_value_o;
  logic        key_valid_o;
  logic        key_press_o;

  logic [15:0] keys = 16'h0000;  // bit r*4+c = key at row r, column c pressed

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;
  int stab     = 0;
  int prev_hit = 0, prev_code = 0;
  int cmt_valid = 0, cmt_code = 0;
  int press_count = 0;
  logic [3:0] exp_value = 4'h0;
  logic       exp_valid = 1'b0;
  logic       exp_press = 1'b0;

  int         keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  logic [3:0] colseq[4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 clk_i = ~clk_i;

  kypd_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .row_i       (row_i),
    .col_o       (col_o),
    .key_value_o (key_value_o),
    .key_valid_o (key_valid_o),
    .key_press_o (key_press_o)
  );

  // Passive keypad: a row is pulled low when a pressed key joins it to a driven column
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", nm, act, exp, edges, $time);
    end
  endtask

  task automatic model_reset();
    edges = 0; stab = 0; prev_hit = 0; prev_code = 0;
    cmt_valid = 0; cmt_code = 0;
    exp_value = 4'h0; exp_valid = 1'b0; exp_press = 1'b0;
  endtask

  // Whole-scan result from the key set held during the scan, then debounce/commit
  task automatic end_scan();
    int rh, rc;
    rh = 0; rc = 0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (rh == 0 && keys[r*4+c]) begin
          rh = 1;
          rc = keymap[r*4+c];
        end
    if (rh == prev_hit && rc == prev_code) stab = (stab + 1 > DB) ? DB : stab + 1;
    else stab = 1;
    prev_hit = rh; prev_code = rc;
    if (stab == DB && (rh != cmt_valid || rc != cmt_code)) begin
      cmt_valid = rh; cmt_code = rc;
      exp_valid = (rh != 0);
      if (rh != 0) begin
        exp_value = 4'(rc);
        exp_press = 1'b1;
      end else begin
`ifdef KYPD_HOLD_LAST_EN
        exp_value = exp_value;
`else
        exp_value = 4'h0;
`endif
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      if (!rst_i) begin
        edges++;
        exp_press = 1'b0;
        if (edges % SCAN == 0) end_scan();
      end
    end
  endtask

  always @(negedge clk_i) begin
    logic [3:0] ec;
    ec = ~(4'b0001 << ((edges / SD) % 4));
    chk("col_o", 16'(col_o), 16'(ec));
    chk("key_value_o", 16'(key_value_o), 16'(exp_value));
    chk("key_valid_o", 16'(key_valid_o), 16'(exp_valid));
    chk("key_press_o", 16'(key_press_o), 16'(exp_press));
    if (key_press_o === 1'b1) press_count++;
  end

  initial begin
    int pc0;
    int mode, hold;
    logic [15:0] rk;

    // Reset and idle column walk
    keys = 16'h0000;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("reset col", 16'(col_o), 16'(4'b1110));
    chk("reset valid", 16'(key_valid_o), 16'd0);
    for (int k = 1; k < 8; k++) begin
      step(SD);
      chk("col walk", 16'(col_o), 16'(colseq[k % 4]));
    end
    step(SD);
    chk("idle valid", 16'(key_valid_o), 16'd0);
    chk("idle value", 16'(key_value_o), 16'd0);

    // Key "5" held from reset release
    rst_i = 1'b1; model_reset();
    keys = 16'h0020;
    step(2);
    rst_i = 1'b0;
    pc0 = press_count;
    step(47);
    chk("5 not yet", 16'(key_valid_o), 16'd0);
    step(1);
    chk("5 value", 16'(key_value_o), 16'h5);
    chk("5 valid", 16'(key_valid_o), 16'd1);
    chk("5 press", 16'(key_press_o), 16'd1);
    step(1);
    chk("5 press drop", 16'(key_press_o), 16'd0);
    step(15);
    chk("5 pulse count", 16'(press_count - pc0), 16'd1);

    // Release
    keys = 16'h0000;
    step(3 * SCAN);
    chk("release valid", 16'(key_valid_o), 16'd0);
`ifdef KYPD_HOLD_LAST_EN
    chk("release value", 16'(key_value_o), 16'h5);
`else
    chk("release value", 16'(key_value_o), 16'h0);
`endif

    // Glitch: "C" for 2 scans only
    pc0 = press_count;
    keys = 16'h0800;
    step(2 * SCAN);
    keys = 16'h0000;
    step(3 * SCAN);
    chk("glitch valid", 16'(key_valid_o), 16'd0);
    chk("glitch pulses", 16'(press_count - pc0), 16'd0);

    // "2" and "D" together, then "D" alone
    keys = 16'h8002;
    step(4 * SCAN);
    chk("multi value", 16'(key_value_o), 16'h2);
    chk("multi valid", 16'(key_valid_o), 16'd1);
    pc0 = press_count;
    keys = 16'h8000;
    step(4 * SCAN);
    chk("D value", 16'(key_value_o), 16'hD);
    chk("D pulses", 16'(press_count - pc0), 16'd1);

    // Reset during COL2 with "9" committed
    keys = 16'h0400;
    step(4 * SCAN);
    chk("9 value", 16'(key_value_o), 16'h9);
    step(9);
    rst_i = 1'b1; model_reset();
    #1;
    chk("midrst col", 16'(col_o), 16'(4'b1110));
    chk("midrst value", 16'(key_value_o), 16'd0);
    chk("midrst valid", 16'(key_valid_o), 16'd0);
    step(2);
    rst_i = 1'b0;
    step(48);
    chk("9 recommit value", 16'(key_value_o), 16'h9);
    chk("9 recommit press", 16'(key_press_o), 16'd1);
    step(16);

    // Randomized key sets held for whole scans
    for (int s = 0; s < 40; s++) begin
      mode = $urandom_range(0, 3);
      rk = 16'($urandom) & 16'($urandom);
      if (mode == 0) keys = 16'h0000;
      else if (mode == 1) keys = 16'h0001 << $urandom_range(0, 15);
      else keys = rk | (16'h0001 << $urandom_range(0, 15));
      hold = $urandom_range(1, 5);
      step(hold * SCAN);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
